seq_mult_unit: RTL and testbench

Parametrised iterative shift-add multiplier: the next generation of the pipeline's 32-bit sequential multiplier. It adds configurable operand width, multiple multiplier bits retired per cycle, a start/busy/done handshake, a flush, and an optional multiply-accumulate mode for MADD-style instructions. It sits beside the ALU in the execute stage. The issue logic holds the dependent instruction until `done`.

---
 rtl/seq_mult_unit_if.sv | 28 ++
 rtl/seq_mult_unit.sv | 112 +++++++++++
 tb/tb_seq_mult_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_unit_if.sv
// Issue-side bundle for the iterative multiplier.
// master drives requests; slave is the multiplier.
interface seq_mult_unit_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   flush;
    logic                   sign;
    logic                   accumulate;
    logic [WIDTH-1:0]       op_a;
    logic [WIDTH-1:0]       op_b;
    logic [2*WIDTH-1:0]     acc_in;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, flush, sign, accumulate,
        output op_a, op_b, acc_in,
        input  busy, done, product
    );

    modport slave (
        input  start, flush, sign, accumulate,
        input  op_a, op_b, acc_in,
        output busy, done, product
    );
endinterface

// File: rtl/seq_mult_unit.sv
// Iterative shift-add multiplier retiring STEP multiplier bits per cycle,
// with signed/unsigned operands and optional accumulate.
module seq_mult_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_mult_unit_if.slave bus
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state;
    state_t               state_nx;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   signed_sum;
    logic [2*WIDTH-1:0]   fixed;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [CW-1:0]        cnt;
    logic                 neg;
    logic                 acc_en;
    logic                 accept;
    logic                 busy_nx;
    logic                 done_nx;

    assign accept = (state == IDLE) && bus.start && !bus.flush;

    // Most-negative operand negates to itself, which reads correctly as unsigned.
    assign mag_a = (bus.sign && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
    assign mag_b = (bus.sign && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;

    always_comb begin
        addend = '0;
        for (int k = 0; k < STEP; k++) begin
            if (mplier[k]) addend = addend + (mcand << k);
        end
    end

    assign signed_sum = neg ? -partial : partial;
    assign fixed      = signed_sum + (acc_en ? acc_q : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = RUN;
            RUN: begin
                if (bus.flush)            state_nx = IDLE;
                else if (cnt == CW'(1))   state_nx = FIX;
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy_nx = (state_nx != IDLE);
        done_nx = (state == FIX) && !bus.flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.busy <= busy_nx;
            bus.done <= done_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            partial <= '0;
            acc_q   <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            acc_en  <= 1'b0;
        end else if (accept) begin
            mcand   <= {{WIDTH{1'b0}}, mag_a};
            mplier  <= mag_b;
            partial <= '0;
            acc_q   <= bus.acc_in;
            cnt     <= CW'(N);
            neg     <= bus.sign & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            acc_en  <= bus.accumulate;
        end else if (state == RUN && !bus.flush) begin
            partial <= partial + addend;
            mplier  <= mplier >> STEP;
            mcand   <= mcand << STEP;
            cnt     <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         bus.product <= '0;
        else if (state == FIX && !bus.flush) bus.product <= fixed;
    end
endmodule

// File: tb/tb_seq_mult_unit.sv
// Scoreboard bench for seq_mult_unit: a 32-bit STEP=1 unit
// and a 16-bit STEP=4 unit driven with directed vectors.
module tb_seq_mult_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    typedef struct {
        logic [63:0] prod;
        int          acc_cyc;
        int          lat;
        string       nm;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];

    seq_mult_unit_if #(.WIDTH(32)) if32 ();
    seq_mult_unit_if #(.WIDTH(16)) if16 ();

    seq_mult_unit #(.WIDTH(32), .STEP(1)) u32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if32)
    );

    seq_mult_unit #(.WIDTH(16), .STEP(4)) u16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && if32.done) begin
            if (q32.size() == 0) begin
                check("done32_unexpected", 64'd1, 64'd0);
            end else begin
                e = q32.pop_front();
                check({e.nm, "_prod"}, if32.product, e.prod);
                check({e.nm, "_lat"}, 64'(cyc - e.acc_cyc), 64'(e.lat));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && if16.done) begin
            if (q16.size() == 0) begin
                check("done16_unexpected", 64'd1, 64'd0);
            end else begin
                e = q16.pop_front();
                check({e.nm, "_prod"}, {32'd0, if16.product}, e.prod);
                check({e.nm, "_lat"}, 64'(cyc - e.acc_cyc), 64'(e.lat));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue32(input string nm, input logic s, input logic ac,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] acc, input logic [63:0] exp,
                           input bit push);
        if32.start = 1'b1;
        if32.sign = s;
        if32.accumulate = ac;
        if32.op_a = a;
        if32.op_b = b;
        if32.acc_in = acc;
        @(posedge clk);
        #1;
        if (push) q32.push_back('{exp, cyc, 33, nm});
        @(negedge clk);
        if32.start = 1'b0;
        if32.sign = ~s;
        if32.accumulate = ~ac;
        if32.op_a = ~a;
        if32.op_b = ~b;
        if32.acc_in = ~acc;
    endtask

    task automatic issue16(input string nm, input logic s, input logic ac,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] acc, input logic [31:0] exp);
        if16.start = 1'b1;
        if16.sign = s;
        if16.accumulate = ac;
        if16.op_a = a;
        if16.op_b = b;
        if16.acc_in = acc;
        @(posedge clk);
        #1;
        q16.push_back('{{32'd0, exp}, cyc, 5, nm});
        @(negedge clk);
        if16.start = 1'b0;
        if16.op_a = ~a;
        if16.op_b = ~b;
        if16.acc_in = ~acc;
    endtask

    task automatic wait_idle32();
        int n = 0;
        while (if32.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (if32.busy) check("timeout32", 64'd1, 64'd0);
    endtask

    task automatic wait_idle16();
        int n = 0;
        while (if16.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (if16.busy) check("timeout16", 64'd1, 64'd0);
    endtask

    initial begin
        if32.start = 0; if32.flush = 0; if32.sign = 0; if32.accumulate = 0;
        if32.op_a = 0; if32.op_b = 0; if32.acc_in = 0;
        if16.start = 0; if16.flush = 0; if16.sign = 0; if16.accumulate = 0;
        if16.op_a = 0; if16.op_b = 0; if16.acc_in = 0;
        #1;
        check("rst_busy32", {63'd0, if32.busy}, 64'd0);
        check("rst_done32", {63'd0, if32.done}, 64'd0);
        check("rst_prod32", if32.product, 64'd0);
        check("rst_busy16", {63'd0, if16.busy}, 64'd0);
        check("rst_done16", {63'd0, if16.done}, 64'd0);
        check("rst_prod16", {32'd0, if16.product}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue32("u_max", 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0,
                64'hFFFFFFFE00000001, 1);
        wait_idle32(); @(negedge clk);
        issue32("s_m7x6", 1, 0, 32'hFFFFFFF9, 32'd6, 64'd0,
                64'hFFFFFFFFFFFFFFD6, 1);
        wait_idle32(); @(negedge clk);
        issue32("s_min_sq", 1, 0, 32'h80000000, 32'h80000000, 64'd0,
                64'h4000000000000000, 1);
        wait_idle32(); @(negedge clk);
        issue32("s_min_x1", 1, 0, 32'h80000000, 32'd1, 64'd0,
                64'hFFFFFFFF80000000, 1);
        wait_idle32(); @(negedge clk);
        issue32("acc_s", 1, 1, 32'hFFFFFFFF, 32'd1, 64'h0000000100000000,
                64'h00000000FFFFFFFF, 1);
        wait_idle32(); @(negedge clk);
        issue32("acc_wrap", 0, 1, 32'd1, 32'd1, 64'hFFFFFFFFFFFFFFFF,
                64'd0, 1);
        wait_idle32(); @(negedge clk);

        // start mid-RUN must not disturb the first result
        issue32("run_start", 0, 0, 32'd3, 32'd4, 64'd0, 64'd12, 1);
        repeat (5) @(negedge clk);
        if32.start = 1'b1;
        if32.op_a = 32'd9;
        if32.op_b = 32'd9;
        @(negedge clk);
        if32.start = 1'b0;
        wait_idle32(); @(negedge clk);

        issue32("flushed", 0, 0, 32'd5, 32'd7, 64'd0, 64'd35, 0);
        repeat (9) @(negedge clk);
        if32.flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_busy", {63'd0, if32.busy}, 64'd0);
        @(negedge clk);
        if32.flush = 1'b0;
        repeat (40) @(negedge clk);
        check("flush_prod", if32.product, 64'd12);

        issue16("w16_1234", 0, 0, 16'h1234, 16'hABCD, 32'd0, 32'h0C374FA4);
        wait_idle16();
        issue16("w16_b2b", 0, 0, 16'd3, 16'd5, 32'd0, 32'h0000000F);
        wait_idle16(); @(negedge clk);
        issue16("w16_m1sq", 1, 0, 16'hFFFF, 16'hFFFF, 32'd0, 32'h00000001);
        wait_idle16(); @(negedge clk);
        issue16("w16_minsq", 1, 0, 16'h8000, 16'h8000, 32'd0, 32'h40000000);
        wait_idle16(); @(negedge clk);
        issue16("w16_acc", 1, 1, 16'hFFFE, 16'd3, 32'h10, 32'h0000000A);
        wait_idle16(); @(negedge clk);

        issue32("reset_mid", 0, 0, 32'h1234, 32'h5678, 64'd0, 64'd0, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", {63'd0, if32.busy}, 64'd0);
        check("arst_done", {63'd0, if32.done}, 64'd0);
        check("arst_prod", if32.product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        check("q32_empty", 64'(q32.size()), 64'd0);
        check("q16_empty", 64'(q16.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
